// File: rtl/sync_debounce_bank.sv
// sync_debounce_bank
//   Multi-channel input conditioner for asynchronous board inputs such as
//   pushbuttons, switches and external strobes. Each channel is processed
//   independently in three steps:
//     1. A plain flip-flop synchroniser chain, SYNC_STAGES deep.
//     2. A debounce counter. It moves the clean level ds only after the
//        synchronised input has differed from ds for DEB_CYCLES consecutive
//        cycles.
//     3. Registered one-cycle rise/fall pulses, aligned with the ds update.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   dato        in   N   asynchronous raw inputs, one bit per channel
//   ds          out  N   debounced, synchronised level per channel
//   rise        out  N   one-cycle pulse when ds[i] goes 0->1
//   fall        out  N   one-cycle pulse when ds[i] goes 1->0
//   any_change  out  1   OR of all rise/fall bits, same cycle as the pulses
module sync_debounce_bank #(
  parameter int             N           = 4,
  parameter int             SYNC_STAGES = 2,
  parameter int             DEB_CYCLES  = 4,
  parameter logic [N-1:0]   RESET_VAL   = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] dato,
  output logic [N-1:0] ds,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         any_change
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [N-1:0]  r_sync [SYNC_STAGES];
  logic [CW-1:0] r_cnt  [N];
  logic [N-1:0]  r_ds;
  logic [N-1:0]  r_rise;
  logic [N-1:0]  r_fall;
  logic          r_any;

  logic [N-1:0]  w_s;
  logic [N-1:0]  w_ds_nxt;
  logic [CW-1:0] w_cnt_nxt [N];
  logic [N-1:0]  w_rise_nxt;
  logic [N-1:0]  w_fall_nxt;

  // Debounce step for one channel. It returns {next level, next count}.
  // A mismatch that has already lasted DEB_CYCLES-1 cycles commits the new
  // level on this edge and clears the count. Any agreement between the
  // input and ds also clears the count, so a bounce restarts from zero.
  // Because of this the count never passes CNT_LAST and cannot wrap.
  function automatic logic [CW:0] deb_step(input logic s, input logic d,
                                           input logic [CW-1:0] cnt);
    logic [CW:0] res;
    res = {d, {CW{1'b0}}};
    if (s != d) begin
      if (cnt == CNT_LAST) res = {s, {CW{1'b0}}};
      else                 res = {d, cnt + CW'(1)};
    end
    return res;
  endfunction

  // Synchroniser stage boundary: pure shift chain, no logic between flops
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= RESET_VAL;
    end else begin
      r_sync[0] <= dato;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_ds_nxt = r_ds;
    for (int i = 0; i < N; i++) begin
      logic [CW:0] w_step;
      w_step       = deb_step(w_s[i], r_ds[i], r_cnt[i]);
      w_ds_nxt[i]  = w_step[CW];
      w_cnt_nxt[i] = w_step[CW-1:0];
    end
    w_rise_nxt = w_ds_nxt & ~r_ds;
    w_fall_nxt = ~w_ds_nxt & r_ds;
  end

  // Debounce/edge stage boundary: level and pulses register on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
      r_ds   <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_ds   <= w_ds_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      r_any  <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign ds         = r_ds;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign any_change = r_any;

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank with default parameters.
// Inputs change 1 ns after a rising edge. Outputs are checked 1 ns after
// the edge that produced them. "Edge n" below is the n-th rising edge after
// an input change, and edge 1 captures the new value.
module tb_sync_debounce_bank;

  logic       clk;
  logic       reset;
  logic [3:0] dato;
  logic [3:0] ds;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_change;

  int n_chk;
  int n_err;

  sync_debounce_bank #(
    .N(4), .SYNC_STAGES(2), .DEB_CYCLES(4), .RESET_VAL(4'b0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dato(dato),
    .ds(ds),
    .rise(rise),
    .fall(fall),
    .any_change(any_change)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] e_ds,
                     input logic [3:0] e_rise, input logic [3:0] e_fall,
                     input logic e_any);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {ds, rise, fall, any_change};
    exp = {e_ds, e_rise, e_fall, e_any};
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s ds/rise/fall/any observed=%b_%b_%b_%b expected=%b_%b_%b_%b",
             tag, obs[12:9], obs[8:5], obs[4:1], obs[0],
             exp[12:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  // n edges with the level held at e_ds and no pulses expected
  task automatic quiet(input string tag, input int n, input logic [3:0] e_ds);
    for (int k = 0; k < n; k++) begin
      tick();
      chk(tag, e_ds, 4'b0000, 4'b0000, 1'b0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    // 1. Reset held for two edges with all inputs high
    reset = 1'b1;
    dato  = 4'b1111;
    tick();
    chk("reset_edge1", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    chk("reset_edge2", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    dato  = 4'b0000;
    tick();
    chk("post_release", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    quiet("idle", 2, 4'b0000);

    // 2. Channel 0 rises; ds changes on edge 6
    dato = 4'b0001;
    quiet("rise_wait", 5, 4'b0000);
    tick();
    chk("rise_ch0", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    tick();
    chk("rise_ch0_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // 3a. Channel 1 glitch of 3 captured cycles is rejected
    dato = 4'b0011;
    quiet("glitch3_hi", 3, 4'b0001);
    dato = 4'b0001;
    quiet("glitch3_lo", 8, 4'b0001);

    // 3b. Exactly 4 captured cycles is accepted. ds[1] falls again after the
    //     return to 0 is captured on edge 5 (5 + 6 - 1 = edge 10).
    dato = 4'b0011;
    quiet("pulse4_hi", 4, 4'b0001);
    dato = 4'b0001;
    quiet("pulse4_e5", 1, 4'b0001);
    tick();
    chk("pulse4_rise", 4'b0011, 4'b0010, 4'b0000, 1'b1);
    quiet("pulse4_hold", 3, 4'b0011);
    tick();
    chk("pulse4_fall", 4'b0001, 4'b0000, 4'b0010, 1'b1);
    quiet("pulse4_after", 1, 4'b0001);

    // 4. Channel 0 bounces with 2-cycle segments, then settles low
    dato = 4'b0000;
    quiet("bounce_lo1", 2, 4'b0001);
    dato = 4'b0001;
    quiet("bounce_hi", 2, 4'b0001);
    dato = 4'b0000;
    quiet("bounce_final", 5, 4'b0001);
    tick();
    chk("bounce_fall", 4'b0000, 4'b0000, 4'b0001, 1'b1);
    quiet("bounce_after", 1, 4'b0000);

    // 5. Channels 3 and 2 rise together
    dato = 4'b1100;
    quiet("simul_wait", 5, 4'b0000);
    tick();
    chk("simul_rise", 4'b1100, 4'b1100, 4'b0000, 1'b1);
    quiet("simul_after", 1, 4'b1100);
    dato = 4'b0000;
    quiet("simul_fall_wait", 5, 4'b1100);
    tick();
    chk("simul_fall", 4'b0000, 4'b0000, 4'b1100, 1'b1);
    quiet("simul_fall_after", 1, 4'b0000);

    // 6. Reset while cnt[2]==2 (after edge 4). Without the reset, the
    //    toggle would have happened on edge 6.
    dato = 4'b0100;
    quiet("midrst_count", 4, 4'b0000);
    reset = 1'b1;
    tick();
    chk("midrst_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    quiet("midrst_release", 5, 4'b0000);
    tick();
    chk("midrst_rise", 4'b0100, 4'b0100, 4'b0000, 1'b1);
    quiet("midrst_after", 1, 4'b0100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
